// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared floor-call types and default sizing
package lift_pkg;

  localparam int DEFAULT_NUM_FLOORS = 8;
  localparam int DEFAULT_FLOOR_W    = $clog2(DEFAULT_NUM_FLOORS);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } panel_state_e;

  typedef logic [DEFAULT_FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/rr_floor_picker.sv
// rtl/rr_floor_picker.sv - round-robin pick of the first candidate strictly after ptr
module rr_floor_picker #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] index,
  output logic         found
);

  int best_d;
  int d;

  // Distance from ptr+1 going upward with wrap; the smallest distance wins.
  always_comb begin
    found  = 1'b0;
    index  = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i - int'(ptr) - 1 + 2 * N) % N;
      if (cand[i] && d < best_d) begin
        best_d = d;
        index  = W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floor_call_panel.sv
// rtl/floor_call_panel.sv - floor button latching, lamp tracking and one-at-a-time call issue
module floor_call_panel
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = DEFAULT_FLOOR_W,
  parameter int HOLD_CYC   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FLOORS-1:0]         button,
  input  logic [FLOOR_W-1:0]            current_floor,
  input  logic                          door_open,
  input  logic                          emergency_stop,
  input  logic                          req_ack,
  output logic [FLOOR_W-1:0]            req_floor,
  output logic                          req_valid,
  output logic [NUM_FLOORS-1:0]         lamps,
  output logic [$clog2(NUM_FLOORS+1)-1:0] pending_count,
  output logic                          busy
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam int PC_W  = $clog2(NUM_FLOORS + 1);

  panel_state_e            state, state_n;
  logic [NUM_FLOORS-1:0]   btn_q;
  logic [NUM_FLOORS-1:0]   sent;
  logic [FLOOR_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]        hold_cnt;

  logic [NUM_FLOORS-1:0]   rise;
  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   set_mask;
  logic [NUM_FLOORS-1:0]   cand;
  logic [FLOOR_W-1:0]      pick_idx;
  logic                    pick_found;
  logic                    load_req;
  logic                    do_ack;
  logic                    req_serviced;

  assign rise = button & ~btn_q;
  // Out-of-range floors shift the bit off the top, so nothing clears.
  assign clr  = door_open ? (NUM_FLOORS'(1) << current_floor) : '0;
  assign cand = lamps & ~sent;
  assign req_serviced = door_open && (current_floor == req_floor);
  assign set_mask = do_ack ? (NUM_FLOORS'(1) << req_floor) : '0;

  rr_floor_picker #(
    .N(NUM_FLOORS),
    .W(FLOOR_W)
  ) u_picker (
    .cand (cand),
    .ptr  (rr_ptr),
    .index(pick_idx),
    .found(pick_found)
  );

  always_comb begin
    state_n  = state;
    load_req = 1'b0;
    do_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!emergency_stop && pick_found) begin
          load_req = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        // Aborts beat an acknowledge arriving in the same cycle.
        if (emergency_stop || req_serviced) begin
          state_n = IDLE;
        end else if (req_ack) begin
          do_ack  = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt <= CNT_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      btn_q     <= '0;
      lamps     <= '0;
      sent      <= '0;
      req_floor <= '0;
      rr_ptr    <= FLOOR_W'(NUM_FLOORS - 1);
      hold_cnt  <= '0;
    end else begin
      state <= state_n;
      btn_q <= button;
      lamps <= (lamps | rise) & ~clr;
      sent  <= (sent | set_mask) & ~clr;
      if (load_req) req_floor <= pick_idx;
      if (do_ack) begin
        rr_ptr   <= req_floor;
        hold_cnt <= CNT_W'(HOLD_CYC);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      pending_count = pending_count + PC_W'(lamps[i]);
    end
  end

  assign req_valid = (state == SEND);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_floor_call_panel.sv
// tb/tb_floor_call_panel.sv - directed self-checking bench for floor_call_panel
module tb_floor_call_panel;
  import lift_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   button;
  floor_t       current_floor;
  logic         door_open;
  logic         emergency_stop;
  logic         req_ack;
  floor_t       req_floor;
  logic         req_valid;
  logic [7:0]   lamps;
  logic [3:0]   pending_count;
  logic         busy;

  int errors = 0;
  int checks = 0;

  floor_call_panel #(
    .NUM_FLOORS(8),
    .FLOOR_W   (3),
    .HOLD_CYC  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button        (button),
    .current_floor (current_floor),
    .door_open     (door_open),
    .emergency_stop(emergency_stop),
    .req_ack       (req_ack),
    .req_floor     (req_floor),
    .req_valid     (req_valid),
    .lamps         (lamps),
    .pending_count (pending_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, req_valid, 1);
  endtask

  task automatic ack_expect(input string tag, input floor_t f);
    wait_valid(tag);
    check({tag, "_floor"}, req_floor, f);
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    check({tag, "_ackd"}, req_valid, 0);
    check({tag, "_hold"}, busy, 1);
    check({tag, "_held1"}, req_floor, f);
    step();
    check({tag, "_held2"}, req_floor, f);
    check({tag, "_hold2"}, busy, 1);
    step();
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic service(input floor_t f);
    current_floor = f;
    door_open     = 1'b1;
    step();
    door_open     = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    button = '0;
    current_floor = '0;
    door_open = 1'b0;
    emergency_stop = 1'b0;
    req_ack = 1'b0;
    step();
    step();
    check("rst_lamps", lamps, 0);
    check("rst_valid", req_valid, 0);
    check("rst_floor", req_floor, 0);
    check("rst_pending", pending_count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // single press, latency and hold window
    button = 8'h20;
    step();
    button = 8'h00;
    check("t1_lamps", lamps, 8'h20);
    check("t1_nvalid", req_valid, 0);
    step();
    check("t1_valid_lat", req_valid, 1);
    check("t1_floor_lat", req_floor, 5);
    ack_expect("t1", 5);
    service(5);
    check("t1_cleared", lamps, 0);

    reset = 1'b1;
    step();
    reset = 1'b0;

    // three simultaneous presses, pointer at 7
    button = 8'h45;
    step();
    button = 8'h00;
    check("t2_lamps", lamps, 8'h45);
    check("t2_pend", pending_count, 3);
    ack_expect("t2a", 0);
    check("t2a_pend", pending_count, 3);
    ack_expect("t2b", 2);
    check("t2b_pend", pending_count, 3);
    ack_expect("t2c", 6);
    check("t2c_pend", pending_count, 3);
    service(0);
    check("t2_svc0", pending_count, 2);
    service(2);
    check("t2_svc2", pending_count, 1);
    service(6);
    check("t2_svc6", pending_count, 0);

    // held button does not relatch after service
    button = 8'h08;
    step();
    check("t3_lamps", lamps, 8'h08);
    ack_expect("t3", 3);
    service(3);
    check("t3_svc", lamps, 0);
    check("t3_pend", pending_count, 0);
    step();
    step();
    check("t3_held", lamps, 0);
    check("t3_busy", busy, 0);
    button = 8'h00;
    step();
    button = 8'h08;
    step();
    check("t3_repress", lamps, 8'h08);
    wait_valid("t3b");
    check("t3b_floor", req_floor, 3);
    current_floor = 3'd3;
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    button = 8'h00;
    check("t3b_abort", req_valid, 0);
    check("t3b_busy", busy, 0);
    check("t3b_lamps", lamps, 0);

    // emergency suspends issuing but not latching
    button = 8'h10;
    step();
    button = 8'h00;
    wait_valid("t4");
    check("t4_floor", req_floor, 4);
    emergency_stop = 1'b1;
    step();
    check("t4_stop", req_valid, 0);
    check("t4_lamp", lamps, 8'h10);
    button = 8'h02;
    step();
    button = 8'h00;
    check("t4_press", lamps, 8'h12);
    step();
    check("t4_susp", req_valid, 0);
    check("t4_susp_busy", busy, 0);
    emergency_stop = 1'b0;
    step();
    check("t4_resume", req_valid, 1);
    check("t4_resume_fl", req_floor, 4);
    ack_expect("t4a", 4);
    ack_expect("t4b", 1);
    service(4);
    service(1);
    check("t4_clear", lamps, 0);

    // service beats ack in the same cycle
    button = 8'h80;
    step();
    button = 8'h00;
    wait_valid("t5");
    check("t5_floor", req_floor, 7);
    req_ack = 1'b1;
    door_open = 1'b1;
    current_floor = 3'd7;
    step();
    req_ack = 1'b0;
    door_open = 1'b0;
    check("t5_valid", req_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_lamps", lamps, 0);
    step();
    check("t5_nohold", busy, 0);

    // asynchronous reset in the middle of HOLD
    button = 8'hFF;
    step();
    button = 8'h00;
    check("t6_lamps", lamps, 8'hFF);
    check("t6_pend", pending_count, 8);
    wait_valid("t6");
    check("t6_floor", req_floor, 2);
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    check("t6_hold", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_lamps", lamps, 0);
    check("t6_rst_valid", req_valid, 0);
    check("t6_rst_floor", req_floor, 0);
    check("t6_rst_pend", pending_count, 0);
    check("t6_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    button = 8'h80;
    step();
    button = 8'h00;
    check("t6_post_lamps", lamps, 8'h80);
    ack_expect("t6_post", 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floor_call_panel.md
Name: floor_call_panel

Overview:
- Request initiator for the car controller. It collects floor-button presses, holds one lamp per floor, and forwards outstanding calls one at a time on req_floor.
- The controller consumes req_floor as a level: it latches whenever the value changes. This block therefore holds each issued value stable for a guaranteed window.
- A call's lamp clears when the controller reports arrival at that floor with the door open.
- Sits between the button/lamp I/O and the controller's req_floor input.

Parameters:
- NUM_FLOORS, 8, number of serviced floors (2..16).
- FLOOR_W, 3, floor index width; must equal $clog2(NUM_FLOORS).
- HOLD_CYC, 2, cycles req_floor is held stable after acknowledge (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- button  input  NUM_FLOORS  synchronous level from floor buttons; bit i high = pressed.
- current_floor  input  FLOOR_W  car position reported by the controller.
- door_open  input  1  high while the controller's door output is open.
- emergency_stop  input  1  high = suspend issuing calls.
- req_ack  input  1  controller accepted the presented req_floor.
- req_floor  output  FLOOR_W  floor index presented to the controller.
- req_valid  output  1  req_floor carries a new call awaiting req_ack.
- lamps  output  NUM_FLOORS  pending-call indicator per floor.
- pending_count  output  $clog2(NUM_FLOORS+1)  popcount of lamps.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, immediate) forces the following; reset mid-transfer aborts with no partial state:
  - lamps=0, sent=0, btn_q=0, req_floor=0, req_valid=0.
  - pending_count=0, busy=0, FSM=IDLE, hold counter=0, rr pointer=NUM_FLOORS-1.
- Press detection:
  - btn_q registers button each cycle; rise[i] = button[i] & ~btn_q[i].
  - A held button registers once.
  - A rise on an already-lit floor is ignored.
- Service clear:
  - When door_open=1, lamps[current_floor] and sent[current_floor] clear on the next edge.
  - If current_floor >= NUM_FLOORS, nothing clears.
  - Simultaneous rise and service at the same floor: service wins, lamp stays 0.
- lamps set on the edge after the rise (1-cycle latency). pending_count is combinational from lamps.
- Candidate set = lamps & ~sent. Selection is round-robin: first candidate index strictly after the rr pointer, wrapping at NUM_FLOORS-1 to 0.
- FSM IDLE:
  - req_valid=0.
  - If emergency_stop=0 and the candidate set is nonzero: latch the selected index into req_floor, go to SEND (req_valid=1 next cycle).
- FSM SEND (req_valid=1, req_floor stable):
  - If emergency_stop=1: go to IDLE, req_valid=0 next cycle, sent unchanged.
  - Else if the presented floor is serviced this cycle (door_open & current_floor==req_floor): go to IDLE, sent unchanged.
  - Else if req_ack=1: set sent[req_floor], rr pointer=req_floor, load the hold counter with HOLD_CYC, go to HOLD.
  - Else remain in SEND indefinitely. Abort conditions take priority over req_ack in the same cycle.
- FSM HOLD:
  - req_valid=0, req_floor unchanged.
  - Counter decrements each cycle; at 1, go to IDLE.
  - Emergency does not shorten HOLD.
- Minimum spacing between two req_floor changes is HOLD_CYC+2 cycles.
- Emergency:
  - Presses still latch and lamps still clear during emergency_stop.
  - Issuing resumes from IDLE the cycle after emergency_stop falls.
- busy = (state != IDLE).

Decomposition:
- Package lift_pkg holds:
  - NUM_FLOORS and FLOOR_W defaults.
  - The panel_state_e enum {IDLE, SEND, HOLD}.
  - A floor_t typedef (logic [FLOOR_W-1:0]).
- One combinational sub-module, rr_floor_picker, takes a candidate vector and a pointer and returns index plus found flag. It is reusable for hall-call panels.

Test Plan:
1. Reset, press button[5] for 1 cycle -> lamps=8'h20 next cycle; req_valid=1 with req_floor=5 two cycles later; req_ack -> req_valid=0, req_floor held 5 for 2 cycles.
2. Press floors 2, 6 and 0 in the same cycle with the pointer at 7 -> issue order 0, 2, 6 (req_ack each); pending_count=3 until serviced.
3. Floor 3 pending and issued; drive current_floor=3, door_open=1 -> lamps[3]=0 next cycle, pending_count decrements. Hold button[3] high throughout -> no re-latch until released and re-pressed.
4. Floor 4 in SEND, assert emergency_stop before ack -> req_valid=0 next cycle, lamps[4] stays 1; press 1 during emergency -> lamps[1]=1; release -> floor 4 re-presented, then 1.
5. Floor 7 in SEND; same cycle req_ack=1 and door_open=1 at current_floor=7 -> abort to IDLE, sent[7]=0, lamps[7]=0, no HOLD entry.
6. Assert reset mid-HOLD with lamps=8'hFF -> all outputs 0 immediately (asynchronously); first post-reset press of 7 issues normally.
